// File: rtl/mitchell_seq_ctrl_if.sv
// Operand/product handshake bundle for the Mitchell multiplier sequencer.
// The master side is the operand source plus product consumer; the slave side is the controller.
interface mitchell_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mitchell_seq_ctrl.sv
// Sequencer for an 8x8 Mitchell approximate multiplier.
// A single leading-one-detect / normalise unit is time-shared between operand A and operand B.
module mitchell_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int FRAC  = WIDTH - 1
) (
    input  logic                clk,
    input  logic                rst,
    mitchell_seq_ctrl_if.slave  bus
);
    localparam int KW = $clog2(WIDTH);
    localparam int CW = 2*WIDTH + FRAC + 1;
    localparam logic [KW:0] WIDTH_C = (KW+1)'(WIDTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOD_A = 3'd1;
    localparam logic [2:0] LOD_B = 3'd2;
    localparam logic [2:0] ADD   = 3'd3;
    localparam logic [2:0] ANTI  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]         state;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [KW-1:0]      ka, kb;
    logic [FRAC-1:0]    fa, fb;
    logic               za, zb;
    logic [FRAC:0]      s_reg;
    logic [KW:0]        k_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic               out_valid_reg;

    logic [WIDTH-1:0]   lod_in;
    logic [KW-1:0]      lod_k;
    logic [KW:0]        lod_sh;
    logic [FRAC-1:0]    lod_frac;
    logic               lod_zero;
    logic [CW-1:0]      wide;
    logic [2*WIDTH-1:0] p_next;

    // Shared normalise unit: B only while in LOD_B, A in every other state.
    always_comb begin
        lod_in = (state == LOD_B) ? b_reg : a_reg;
        lod_k  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lod_in[i]) lod_k = KW'(i);
        end
        lod_sh   = WIDTH_C - (KW+1)'(lod_k) - (KW+1)'(1);
        lod_frac = FRAC'(lod_in << lod_sh);
        lod_zero = (lod_in == '0);
    end

    // Antilog: the mantissa sum either stays below 2.0 or carries into the next power.
    always_comb begin
        wide = '0;
        if (za | zb) begin
            wide = '0;
        end else if (!s_reg[FRAC]) begin
            wide = (((CW'(1) << FRAC) + CW'(s_reg)) << k_reg) >> FRAC;
        end else begin
            wide = ((CW'(s_reg) << k_reg) << 1) >> FRAC;
        end
        p_next = (2*WIDTH)'(wide);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            ka            <= '0;
            kb            <= '0;
            fa            <= '0;
            fb            <= '0;
            za            <= 1'b0;
            zb            <= 1'b0;
            s_reg         <= '0;
            k_reg         <= '0;
            p_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        state <= LOD_A;
                    end
                end
                LOD_A: begin
                    ka    <= lod_k;
                    fa    <= lod_frac;
                    za    <= lod_zero;
                    state <= LOD_B;
                end
                LOD_B: begin
                    kb    <= lod_k;
                    fb    <= lod_frac;
                    zb    <= lod_zero;
                    state <= ADD;
                end
                ADD: begin
                    s_reg <= {1'b0, fa} + {1'b0, fb};
                    k_reg <= {1'b0, ka} + {1'b0, kb};
                    state <= ANTI;
                end
                ANTI: begin
                    p_reg         <= p_next;
                    out_valid_reg <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.p         = p_reg;
endmodule

// File: tb/tb_mitchell_seq_ctrl.sv
// Self-checking bench for mitchell_seq_ctrl: fixed vectors, handshake corner cases and
// random operands against an arithmetic Mitchell reference.
module tb_mitchell_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    mitchell_seq_ctrl_if #(.WIDTH(8)) bus ();

    mitchell_seq_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_p;
    } vec_t;

    vec_t vecs[6];

    // Mitchell product from integer log2 and the scaled mantissa fraction.
    function automatic logic [15:0] refModel(input int x, input int y);
        int     kx, ky, fx, fy, s, k;
        longint prod;
        if (x == 0 || y == 0) return 16'd0;
        kx = 0;
        while ((1 << (kx + 1)) <= x) kx++;
        ky = 0;
        while ((1 << (ky + 1)) <= y) ky++;
        fx = (x - (1 << kx)) * (1 << (7 - kx));
        fy = (y - (1 << ky)) * (1 << (7 - ky));
        s  = fx + fy;
        k  = kx + ky;
        if (s < 128) prod = (longint'(128 + s) << k) >> 7;
        else         prod = (longint'(s) << (k + 1)) >> 7;
        return prod[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Runs one transaction from IDLE; hold=0 keeps out_ready high throughout.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input int hold,
                                 input logic [15:0] exp_p);
        int lat;
        checkOutput("in_ready_before", 32'(bus.in_ready), 32'd1);
        bus.a         = ta;
        bus.b         = tb;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            checkOutput("in_ready_busy", 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'($urandom);
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        checkOutput("latency", 32'(lat), 32'd4);
        checkOutput("product", 32'(bus.p), 32'(exp_p));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_p", 32'(bus.p), 32'(exp_p));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("drain_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("drain_busy", 32'(bus.busy), 32'd0);
        checkOutput("p_held_idle", 32'(bus.p), 32'(exp_p));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_p"}, 32'(bus.p), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'd3,   8'd5,   16'd14};
        vecs[1] = '{8'd255, 8'd255, 16'd65024};
        vecs[2] = '{8'd128, 8'd128, 16'd16384};
        vecs[3] = '{8'd1,   8'd1,   16'd1};
        vecs[4] = '{8'd0,   8'd77,  16'd0};
        vecs[5] = '{8'd7,   8'd9,   16'd60};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("reset");

        for (int i = 0; i < 6; i++) begin
            checkOutput("ref_table", 32'(refModel(int'(vecs[i].a), int'(vecs[i].b))), 32'(vecs[i].exp_p));
            applyStimulus(vecs[i].a, vecs[i].b, 0, vecs[i].exp_p);
        end

        applyStimulus(8'd3, 8'd5, 6, 16'd14);

        // Reset while in ANTI: the in-flight product must never appear.
        bus.a = 8'd255; bus.b = 8'd255; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkResetState("rst_anti");
        applyStimulus(8'd7, 8'd9, 0, 16'd60);

        // Reset while DONE is presenting a result.
        bus.a = 8'd3; bus.b = 8'd5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("done_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkResetState("rst_done");
        applyStimulus(8'd7, 8'd9, 0, 16'd60);

        for (int n = 0; n < 200; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n % 10 == 0) ra = 8'd0;
            applyStimulus(ra, rb, int'($urandom_range(0, 3)), refModel(int'(ra), int'(rb)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
